// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and transfer constants for the SPI master controller
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_HALF_PERIODS = 16;
  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} spi_state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load, shift-left register with enable and serial input
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);
  // load has priority over shift; shift moves toward the MSB and takes sin at the LSB
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= din;
    else if (en) q <= {q[W-2:0], sin};
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode 0 single-byte master sequencer; optional loopback via SPI_LOOPBACK_EN
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_txValid,
  output logic              io_txReady,
  input  logic [DATA_W-1:0] io_txData,
  output logic              io_rxValid,
  output logic [DATA_W-1:0] io_rxData,
  output logic              io_busy,
  output logic              io_sclk,
  output logic              io_mosi,
  input  logic              io_miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              io_loopback,
`endif
  output logic              io_csn
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0] HP_LAST = 4'(SPI_HALF_PERIODS - 1);
  localparam logic [3:0] HP_LAST_FALL = 4'(SPI_HALF_PERIODS - 2);

  spi_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] hp;
  logic sclk_q, sclk_n, csn_q, csn_n, rx_valid_q;
  logic tx_load, tx_en, rx_en, rx_cap;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic tick, rx_sin;

  assign tick = cnt == CNT_LAST;
`ifdef SPI_LOOPBACK_EN
  assign rx_sin = io_loopback ? tx_q[DATA_W-1] : io_miso;
`else
  assign rx_sin = io_miso;
`endif

  // next-state and per-tick actions; sclk rises on leaving SETUP, then toggles each tick
  always_comb begin
    state_n = state;
    sclk_n = sclk_q;
    csn_n = csn_q;
    tx_load = 1'b0;
    tx_en = 1'b0;
    rx_en = 1'b0;
    rx_cap = 1'b0;
    case (state)
      IDLE: if (io_txValid) begin
        state_n = SETUP;
        csn_n = 1'b0;
        tx_load = 1'b1;
      end
      SETUP: if (tick) begin
        state_n = TRANSFER;
        sclk_n = 1'b1;
        rx_en = 1'b1;
      end
      TRANSFER: if (tick) begin
        sclk_n = hp == HP_LAST ? 1'b0 : ~sclk_q;
        rx_en = !sclk_q && hp != HP_LAST;
        tx_en = sclk_q && hp != HP_LAST_FALL;
        state_n = hp == HP_LAST ? HOLD : TRANSFER;
      end
      HOLD: if (tick) begin
        state_n = GAP;
        csn_n = 1'b1;
        rx_cap = 1'b1;
      end
      GAP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, timing counters and registered pin outputs
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hp <= '0;
      sclk_q <= 1'b0;
      csn_q <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      hp <= state != TRANSFER ? '0 : tick ? hp + 1'b1 : hp;
      sclk_q <= sclk_n;
      csn_q <= csn_n;
      rx_valid_q <= rx_cap;
      if (rx_cap) rx_data_q <= rx_q;
    end

  spi_shift_reg #(.W(DATA_W)) u_tx (
    .clock(clock), .reset(reset), .load(tx_load), .din(io_txData),
    .en(tx_en), .sin(1'b0), .q(tx_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clock(clock), .reset(reset), .load(tx_load), .din('0),
    .en(rx_en), .sin(rx_sin), .q(rx_q)
  );

  assign io_txReady = state == IDLE;
  assign io_busy = state != IDLE;
  assign io_sclk = sclk_q;
  assign io_csn = csn_q;
  assign io_mosi = tx_q[DATA_W-1];
  assign io_rxValid = rx_valid_q;
  assign io_rxData = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized scoreboard bench with a behavioural SPI slave
module tb_spi_master_ctrl;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_ready, rx_valid, busy, sclk, mosi, miso, csn;
  logic [7:0] rx_data;
  logic d_valid = 1'b0;
  logic [7:0] d_data = '0;
  logic d_ready, d_rxv, d_busy, d_sclk, d_mosi, d_csn;
  logic [7:0] d_rxd;
  logic force0 = 1'b0;
`ifdef SPI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_master_ctrl #(.CLK_DIV(D)) u_dut (
    .clock(clock), .reset(reset), .io_txValid(tx_valid), .io_txReady(tx_ready),
    .io_txData(tx_data), .io_rxValid(rx_valid), .io_rxData(rx_data), .io_busy(busy),
    .io_sclk(sclk), .io_mosi(mosi), .io_miso(miso),
`ifdef SPI_LOOPBACK_EN
    .io_loopback(loopback),
`endif
    .io_csn(csn)
  );

  spi_master_ctrl #(.CLK_DIV(1)) u_dut1 (
    .clock(clock), .reset(reset), .io_txValid(d_valid), .io_txReady(d_ready),
    .io_txData(d_data), .io_rxValid(d_rxv), .io_rxData(d_rxd), .io_busy(d_busy),
    .io_sclk(d_sclk), .io_mosi(d_mosi), .io_miso(1'b1),
`ifdef SPI_LOOPBACK_EN
    .io_loopback(1'b0),
`endif
    .io_csn(d_csn)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_log[$];
  logic [7:0] exp_rx_q[$], exp_tx_q[$], slave_q[$];
  logic [7:0] sl_sh = '0;
  logic [7:0] mbits, er, et;
  logic psclk = 1'b0;
  logic pcsn = 1'b1;
  int seen_acc = 0;
  int csn_low, rises, first_rise;

  assign miso = force0 ? 1'b0 : sl_sh[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset && tx_valid && tx_ready) acc_log.push_back(cyc);
    cyc++;
  end

  // monitor, scoreboard checker and slave model, all sampled mid-cycle
  always @(negedge clock) begin
    if (acc_log.size() != seen_acc) begin
      seen_acc = acc_log.size();
      csn_low = 0;
      rises = 0;
      first_rise = 0;
      mbits = '0;
    end
    if (pcsn && !csn && slave_q.size() > 0) sl_sh = slave_q.pop_front();
    if (psclk && !sclk && !csn) sl_sh = sl_sh << 1;
    if (!csn) csn_low++;
    if (sclk && !psclk) begin
      rises++;
      if (rises == 1) first_rise = cyc - acc_log[$];
      mbits = {mbits[6:0], mosi};
    end
    if (rx_valid) begin
      if (exp_rx_q.size() == 0) chk("unexpected_rxValid", 1, 0);
      else begin
        er = exp_rx_q.pop_front();
        et = exp_tx_q.pop_front();
        chk("rxData", rx_data, er);
        chk("mosi_bits", mbits, et);
        chk("rxValid_cycle", cyc - acc_log[$], 18 * D + 1);
        chk("csn_low_cycles", csn_low, 18 * D);
        chk("sclk_rises", rises, 8);
        chk("first_rise_cycle", first_rise, D + 1);
        chk("csn_at_done", csn, 1);
      end
    end
    psclk = sclk;
    pcsn = csn;
  end

  task automatic wait_ready(output bit ok);
    int w = 0;
    while (!tx_ready && w < 500) begin @(negedge clock); w++; end
    ok = tx_ready;
    if (!ok) chk("txReady_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] sl, input logic [7:0] rx);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    slave_q.push_back(sl);
    exp_tx_q.push_back(tx);
    exp_rx_q.push_back(rx);
    tx_data = tx;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rel(input int rel);
    int w = 0;
    while (cyc - acc_log[$] != rel && w < 500) begin @(negedge clock); w++; end
    if (w >= 500) chk("wait_rel_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    int n0, w, low, k, fr, lr, nr;
    logic [7:0] tx, sl;
    repeat (3) @(negedge clock);
    chk("rst_txReady", tx_ready, 1);
    chk("rst_rxValid", rx_valid, 0);
    chk("rst_rxData", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_csn", csn, 1);
    reset = 1'b1;
    @(negedge clock);
    send(8'hA5, 8'h3C, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      tx = 8'($urandom);
      sl = 8'($urandom);
      send(tx, sl, sl);
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end
    wait_ready(ok);
    slave_q.push_back(8'h5A);
    slave_q.push_back(8'hC3);
    exp_tx_q.push_back(8'h01);
    exp_tx_q.push_back(8'hFF);
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'hC3);
    n0 = acc_log.size();
    tx_data = 8'h01;
    tx_valid = 1'b1;
    w = 0;
    while (acc_log.size() == n0 && w < 50) begin @(negedge clock); w++; end
    tx_data = 8'hFF;
    low = 0;
    w = 0;
    while (acc_log.size() <= n0 + 1 && w < 200) begin
      if (!tx_ready) low++;
      @(negedge clock);
      w++;
    end
    tx_valid = 1'b0;
    chk("b2b_accepts", acc_log.size(), n0 + 2);
    chk("b2b_gap", acc_log[$] - acc_log[$-1], 19 * D + 1);
    chk("b2b_ready_low", low, 19 * D);
    send(8'($urandom), 8'h77, 8'h77);
    wait_rel(30);
    reset = 1'b0;
    #1;
    chk("abort_csn", csn, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_txReady", tx_ready, 1);
    exp_rx_q.delete();
    exp_tx_q.delete();
    slave_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    send(8'h55, 8'hE1, 8'hE1);
    send(8'($urandom), 8'h9B, 8'h9B);
    wait_rel(18 * D + 2);
    chk("gap_txReady", tx_ready, 0);
    chk("gap_busy", busy, 1);
    chk("gap_csn", csn, 1);
    n0 = acc_log.size();
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("gap_no_accept", acc_log.size(), n0);
    w = 0;
    while (!tx_ready && w < 100) begin @(negedge clock); w++; end
    chk("ready_return_cycle", cyc - acc_log[$], 19 * D + 1);
`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    force0 = 1'b1;
    send(8'h96, 8'h00, 8'h96);
    wait_ready(ok);
    loopback = 1'b0;
    force0 = 1'b0;
`endif
    w = 0;
    while ((exp_rx_q.size() != 0 || !tx_ready) && w < 3000) begin @(negedge clock); w++; end
    chk("drain", exp_rx_q.size(), 0);
    d_data = 8'h80;
    d_valid = 1'b1;
    @(negedge clock);
    d_valid = 1'b0;
    k = 1;
    fr = 0;
    lr = 0;
    nr = 0;
    psclk = psclk;
    while (!d_rxv && k < 100) begin
      if (d_sclk && (nr == 0 || lr != k - 1)) begin
        nr++;
        if (nr == 1) fr = k;
        lr = k;
      end
      @(negedge clock);
      k++;
    end
    chk("d1_rxValid_cycle", k, 19);
    chk("d1_rxData", d_rxd, 8'hFF);
    chk("d1_first_rise", fr, 2);
    chk("d1_rise_span", lr - fr, 14);
    chk("d1_rises", nr, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
